// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: streams L SRAM reads into the N-row skew shift array and flags per-row valid data.
// Optional SKEW_CTRL_PERF_EN adds o_perf_cycles, a saturating busy-cycle counter.
module skew_feed_ctrl #(
    parameter int N        = 8,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 10,
    parameter int SRAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sram_ren_n,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_skew_ren_n,
    output logic [N-1:0]      o_row_valid
`ifdef SKEW_CTRL_PERF_EN
    ,output logic [31:0]      o_perf_cycles
`endif
);
    localparam int P  = SRAM_LAT + N;
    localparam int DW = $clog2(SRAM_LAT + N);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t           r_state, w_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [DW-1:0]    r_dcnt;
    logic [P-1:0]     r_pipe, w_pipe_nxt;
    logic             w_accept, w_kill;
    assign w_accept = (r_state == IDLE) && i_start && !i_abort;
    assign w_kill   = i_abort && (r_state != IDLE);
    // r_pipe[m] is the read strobe delayed m cycles; row i sees it after SRAM_LAT+i
    assign w_pipe_nxt   = w_kill ? '0 : {r_pipe[P-2:0], w_nxt == READ};
    assign o_sram_ren_n = ~r_pipe[0];
    assign o_row_valid  = r_pipe[P-1:SRAM_LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nxt = (i_length == '0) ? DONE : READ;
            READ:    if (r_cnt == '0) w_nxt = DRAIN;
            DRAIN:   if (r_dcnt == '0) w_nxt = DONE;
            default: w_nxt = IDLE;
        endcase
        if (i_abort) w_nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe       <= '0;
            r_cnt        <= '0;
            r_dcnt       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_sram_addr  <= '0;
            o_skew_ren_n <= 1'b1;
        end else begin
            r_pipe       <= w_pipe_nxt;
            o_busy       <= w_nxt != IDLE;
            o_done       <= w_nxt == DONE;
            // enable leads the data window by one cycle for the array's own ren_n register
            o_skew_ren_n <= ~|w_pipe_nxt[SRAM_LAT+N-2:SRAM_LAT-1];
            if (w_accept) begin
                r_cnt       <= i_length - LEN_W'(1);
                o_sram_addr <= i_base_addr;
            end else if (r_state == READ && !i_abort && r_cnt != '0) begin
                r_cnt       <= r_cnt - LEN_W'(1);
                o_sram_addr <= o_sram_addr + ADDR_W'(1);
            end
            if (r_state == READ)
                r_dcnt <= DW'(P - 2);
            else if (r_state == DRAIN && r_dcnt != '0)
                r_dcnt <= r_dcnt - DW'(1);
        end
    end
`ifdef SKEW_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_perf_cycles <= '0;
        else if (w_accept)
            o_perf_cycles <= 32'd1;
        else if (w_nxt != IDLE && o_perf_cycles != 32'hFFFF_FFFF)
            o_perf_cycles <= o_perf_cycles + 32'd1;
    end
`endif
endmodule
